pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 16-bit pipelined MIPS datapath.
- Tracks destination registers of instructions in the EX, MEM and WB stages in an internal scoreboard.
- Generates PC/IF-ID enables, ID/EX bubble insertion, IF-ID flush on taken branch or jump, and ALU operand forwarding selects.
- Freezes the whole pipeline while data memory reports busy, and keeps saturating stall/flush event counters for debug.

Parameters:
- NREG_BITS, 4, register address width (16 registers).
- R0_HARDWIRED, 1, when 1 register 0 never creates a hazard or forward.
- CNT_W, 16, width of the stall and flush counters.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs  in  NREG_BITS  Instr[11:8] of the ID instruction.
- id_rt  in  NREG_BITS  Instr[7:4] of the ID instruction.
- id_uses_rs, id_uses_rt  in  1 each  ID instruction reads that operand.
- id_dst  in  NREG_BITS  Caddr of the ID instruction (after RegDst mux).
- id_regwrite  in  1  control[9] of the ID instruction.
- id_memread  in  1  control[2] of the ID instruction.
- ex_redirect  in  1  taken branch (BranchFlag) or jump resolved in EX this cycle.
- mem_busy  in  1  data memory cannot complete this cycle.
- pc_en  out  1  PC load enable.
- ifid_en  out  1  IF/ID register load enable.
- ifid_flush  out  1  IF/ID loads a bubble.
- idex_bubble  out  1  ID/EX loads a bubble (control zeroed).
- fwd_a, fwd_b  out  2 each  EX operand select: 00 register file, 01 EX/MEM ALUresult, 10 MEM/WB C.
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

Behaviour:
- Scoreboard: three slots EX, MEM, WB. Each slot holds {valid, dst, regwrite, memread}; the EX slot also holds {rs, rt, uses_rs, uses_rt}.
- Reset (async, reset=0):
  - all slots invalid; counters 0.
  - outputs: pc_en=0, ifid_en=0, ifid_flush=0, idex_bubble=1, fwd_a=fwd_b=00.
  - on the first clk edge after release, pc_en and ifid_en resume (combinational from state).
- "match(x,slot)": slot.valid & slot.regwrite & (x==slot.dst) & !(R0_HARDWIRED & x==0).
- load_use = id_valid & EX.memread & ((id_uses_rs & match(id_rs,EX)) | (id_uses_rt & match(id_rt,EX))).
- Combinational outputs, in priority order:
  1. mem_busy=1: freeze. pc_en=0, ifid_en=0, idex_bubble=0, ifid_flush=0; scoreboard holds; no counter change.
  2. ex_redirect=1: pc_en=1, ifid_en=1, ifid_flush=1, idex_bubble=1. This overrides load_use.
  3. load_use=1: pc_en=0, ifid_en=0, idex_bubble=1, ifid_flush=0.
  4. otherwise: pc_en=1, ifid_en=1, idex_bubble=0, ifid_flush=0.
- Forwarding, for the EX slot operands:
  - fwd_a=01 if EX.uses_rs & match(EX.rs,MEM) & !MEM.memread.
  - else fwd_a=10 if EX.uses_rs & match(EX.rs,WB).
  - else fwd_a=00. fwd_b is identical using rt.
  - MEM has priority over WB. A load sitting in MEM never forwards from 01.
- Sequential, on a clk edge when mem_busy=0:
  - WB<=MEM, MEM<=EX.
  - EX<=ID fields if (id_valid & !idex_bubble), else EX.valid<=0.
- Counters:
  - stall_cnt increments on each non-frozen cycle with load_use & !ex_redirect.
  - flush_cnt increments on each non-frozen cycle with ex_redirect.
  - both saturate at all-ones; no wrap.
- Latency: hazard outputs are combinational the same cycle; a load-use stall lasts exactly 1 cycle; a redirect bubbles exactly 2 slots (IF/ID and ID/EX).
- Reset mid-stall or mid-freeze: all state is cleared immediately; no pending stall survives.

Decomposition:
- Shared package pipe_pkg holds:
  - FWD_REG=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10.
  - the slot record layout.
  - NREG_BITS.
- One natural sub-module: hazard_scoreboard, the 3-slot shift register with hold/bubble inputs. Forwarding compare and priority logic stay in the top.

Test Plan:
- Back-to-back ALU ops: R3<=R1+R2, then R4<=R3+R5 -> next cycle fwd_a=01, no stall. One instruction later, a reader of R3 sees fwd_a=10.
- Load R3 followed immediately by a reader of R3 as rt -> 1 cycle of pc_en=0, ifid_en=0, idex_bubble=1, stall_cnt=1; then fwd_b=10 and normal flow.
- Load-use and ex_redirect in the same cycle -> flush wins: ifid_flush=1, idex_bubble=1, pc_en=1, stall_cnt unchanged, flush_cnt=1.
- Writer to R0 followed by a reader of R0 with R0_HARDWIRED=1 -> fwd_a=00 and no stall.
- mem_busy held 3 cycles during a pending load-use -> all enables 0, scoreboard and counters unchanged; after release the load-use stall resolves in exactly 1 cycle.
- reset pulsed low mid-stall and with the counters forced to saturate at 16'hFFFF -> on reset all outputs return to their reset values and the counters read 0. Before reset, a further event leaves the counter at 16'hFFFF.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   NREG_BITS      register address width
//   FWD_*          EX operand forwarding select encodings
//   slot_t         scoreboard entry for MEM/WB (and the common part of EX)
//   ex_slot_t      EX entry: common part plus source operands
//   slot_match()   does register r get written by this slot?
package pipe_pkg;

    localparam int NREG_BITS = 4;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef struct packed {
        logic                 valid;
        logic [NREG_BITS-1:0] dst;
        logic                 regwrite;
        logic                 memread;
    } slot_t;

    typedef struct packed {
        slot_t                base;
        logic [NREG_BITS-1:0] rs;
        logic [NREG_BITS-1:0] rt;
        logic                 uses_rs;
        logic                 uses_rt;
    } ex_slot_t;

    // With r0_hw set, register 0 is a constant and never carries a dependency.
    function automatic logic slot_match(input logic [NREG_BITS-1:0] r,
                                        input slot_t                s,
                                        input logic                 r0_hw);
        return s.valid && s.regwrite && (r == s.dst) && !(r0_hw && (r == '0));
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-slot (EX, MEM, WB) destination scoreboard shadowing the pipeline.
//   clk_i, rst_ni   clock, async active-low reset
//   hold_i          freeze all slots (data memory busy)
//   load_i          EX takes id_slot_i; otherwise EX becomes a bubble
//   id_slot_i       fields of the instruction currently in ID
//   ex_o/mem_o/wb_o current slot contents
module hazard_scoreboard
    import pipe_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     hold_i,
    input  logic     load_i,
    input  ex_slot_t id_slot_i,
    output ex_slot_t ex_o,
    output slot_t    mem_o,
    output slot_t    wb_o
);

    ex_slot_t ex_q, ex_d;
    slot_t    mem_q, mem_d;
    slot_t    wb_q, wb_d;

    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (!hold_i) begin
            wb_d  = mem_q;
            mem_d = ex_q.base;
            // A bubble clears the whole entry so stale operands cannot forward.
            ex_d  = load_i ? id_slot_i : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign ex_o  = ex_q;
    assign mem_o = mem_q;
    assign wb_o  = wb_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 16-bit pipelined MIPS datapath.
// Inputs:  clk_i, reset_ni (async, active low), ID instruction fields
//          (id_valid_i, id_rs_i, id_rt_i, id_uses_rs_i, id_uses_rt_i, id_dst_i,
//          id_regwrite_i, id_memread_i), ex_redirect_i, mem_busy_i.
// Outputs: pc_en_o, ifid_en_o, ifid_flush_o, idex_bubble_o, fwd_a_o, fwd_b_o,
//          stall_cnt_o, flush_cnt_o (saturating debug counters).
// Priority: mem busy freeze > redirect flush > load-use stall > run.
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int R0_HARDWIRED = 1,
    parameter int CNT_W        = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 id_valid_i,
    input  logic [NREG_BITS-1:0] id_rs_i,
    input  logic [NREG_BITS-1:0] id_rt_i,
    input  logic                 id_uses_rs_i,
    input  logic                 id_uses_rt_i,
    input  logic [NREG_BITS-1:0] id_dst_i,
    input  logic                 id_regwrite_i,
    input  logic                 id_memread_i,
    input  logic                 ex_redirect_i,
    input  logic                 mem_busy_i,
    output logic                 pc_en_o,
    output logic                 ifid_en_o,
    output logic                 ifid_flush_o,
    output logic                 idex_bubble_o,
    output logic [1:0]           fwd_a_o,
    output logic [1:0]           fwd_b_o,
    output logic [CNT_W-1:0]     stall_cnt_o,
    output logic [CNT_W-1:0]     flush_cnt_o
);

    localparam logic R0_HW = (R0_HARDWIRED != 0);

    ex_slot_t   id_slot, ex_slot;
    slot_t      mem_slot, wb_slot;
    logic       load_use;
    logic       started_q;
    logic       stall_inc, flush_inc;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic       unused_wb_memread;

    assign id_slot.base.valid    = id_valid_i;
    assign id_slot.base.dst      = id_dst_i;
    assign id_slot.base.regwrite = id_regwrite_i;
    assign id_slot.base.memread  = id_memread_i;
    assign id_slot.rs            = id_rs_i;
    assign id_slot.rt            = id_rt_i;
    assign id_slot.uses_rs       = id_uses_rs_i;
    assign id_slot.uses_rt       = id_uses_rt_i;

    hazard_scoreboard u_scoreboard (
        .clk_i     (clk_i),
        .rst_ni    (reset_ni),
        .hold_i    (mem_busy_i),
        .load_i    (id_valid_i && !idex_bubble_o),
        .id_slot_i (id_slot),
        .ex_o      (ex_slot),
        .mem_o     (mem_slot),
        .wb_o      (wb_slot)
    );

    // A load's result only exists after MEM, so WB is the only source for it.
    assign unused_wb_memread = wb_slot.memread;

    assign load_use = id_valid_i && ex_slot.base.memread &&
                      ((id_uses_rs_i && slot_match(id_rs_i, ex_slot.base, R0_HW)) ||
                       (id_uses_rt_i && slot_match(id_rt_i, ex_slot.base, R0_HW)));

    function automatic logic [1:0] fwd_sel(input logic                 uses,
                                           input logic [NREG_BITS-1:0] r,
                                           input slot_t                m,
                                           input slot_t                w);
        if (uses && slot_match(r, m, R0_HW) && !m.memread) return FWD_EXMEM;
        if (uses && slot_match(r, w, R0_HW))                return FWD_MEMWB;
        return FWD_REG;
    endfunction

    assign fwd_a_o = fwd_sel(ex_slot.uses_rs, ex_slot.rs, mem_slot, wb_slot);
    assign fwd_b_o = fwd_sel(ex_slot.uses_rt, ex_slot.rt, mem_slot, wb_slot);

    always_comb begin
        pc_en_o       = 1'b1;
        ifid_en_o     = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        if (!started_q) begin
            // Between reset release and the first edge the pipe stays parked.
            pc_en_o       = 1'b0;
            ifid_en_o     = 1'b0;
            idex_bubble_o = 1'b1;
        end else if (mem_busy_i) begin
            pc_en_o   = 1'b0;
            ifid_en_o = 1'b0;
        end else if (ex_redirect_i) begin
            ifid_flush_o  = 1'b1;
            idex_bubble_o = 1'b1;
        end else if (load_use) begin
            pc_en_o       = 1'b0;
            ifid_en_o     = 1'b0;
            idex_bubble_o = 1'b1;
        end
    end

    assign stall_inc = started_q && !mem_busy_i && load_use && !ex_redirect_i;
    assign flush_inc = started_q && !mem_busy_i && ex_redirect_i;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_inc && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush_inc && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            started_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            started_q   <= 1'b1;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    logic        clk, reset_n;
    logic        id_valid, id_uses_rs, id_uses_rt, id_regwrite, id_memread;
    logic [3:0]  id_rs, id_rt, id_dst;
    logic        ex_redirect, mem_busy;
    logic        pc_en, ifid_en, ifid_flush, idex_bubble;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt, flush_cnt;
    logic [7:0]  outs;

    int n_checks = 0;
    int n_errors = 0;

    pipeline_hazard_ctrl #(.R0_HARDWIRED(1), .CNT_W(16)) dut (
        .clk_i         (clk),
        .reset_ni      (reset_n),
        .id_valid_i    (id_valid),
        .id_rs_i       (id_rs),
        .id_rt_i       (id_rt),
        .id_uses_rs_i  (id_uses_rs),
        .id_uses_rt_i  (id_uses_rt),
        .id_dst_i      (id_dst),
        .id_regwrite_i (id_regwrite),
        .id_memread_i  (id_memread),
        .ex_redirect_i (ex_redirect),
        .mem_busy_i    (mem_busy),
        .pc_en_o       (pc_en),
        .ifid_en_o     (ifid_en),
        .ifid_flush_o  (ifid_flush),
        .idex_bubble_o (idex_bubble),
        .fwd_a_o       (fwd_a),
        .fwd_b_o       (fwd_b),
        .stall_cnt_o   (stall_cnt),
        .flush_cnt_o   (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign outs = {pc_en, ifid_en, ifid_flush, idex_bubble, fwd_a, fwd_b};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_id(input logic v, input logic [3:0] rs, input logic [3:0] rt,
                            input logic urs, input logic urt, input logic [3:0] dst,
                            input logic rw, input logic mr);
        id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
        id_dst = dst; id_regwrite = rw; id_memread = mr;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        drive_id(0, 0, 0, 0, 0, 0, 0, 0);
        ex_redirect = 1'b0;
        mem_busy = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
    endtask

    // Per-cycle vectors: ID inputs, redirect, busy, then expected outputs that cycle.
    typedef struct {
        logic v; logic [3:0] rs; logic [3:0] rt; logic urs; logic urt;
        logic [3:0] dst; logic rw; logic mr; logic redir; logic busy;
        logic pc; logic ifid; logic fl; logic bub; logic [1:0] fa; logic [1:0] fb;
        int sc; int fc;
    } vec_t;
    vec_t vecs[17];

    // Reference model: instructions resident in EX / MEM / WB.
    typedef struct { logic v; logic [3:0] dst; logic [3:0] rs; logic [3:0] rt;
                     logic rw; logic mr; logic urs; logic urt; } minst_t;
    minst_t m_ex, m_mem, m_wb, m_id, m_nop;
    int     m_sc, m_fc;

    function automatic logic writes(input minst_t s, input logic [3:0] r);
        return s.v && s.rw && (s.dst == r) && (r != 4'd0);
    endfunction

    function automatic logic [1:0] model_fwd(input logic uses, input logic [3:0] r);
        if (!m_ex.v || !uses) return 2'd0;
        if (writes(m_mem, r) && !m_mem.mr) return 2'd1;
        if (writes(m_wb, r)) return 2'd2;
        return 2'd0;
    endfunction

    initial begin
        logic [7:0] exp_o;
        logic lu;
        reset_n = 1'b0;
        drive_id(0, 0, 0, 0, 0, 0, 0, 0);
        ex_redirect = 1'b0;
        mem_busy = 1'b0;

        //         v rs rt urs urt dst rw mr rd bz  pc if fl bu fa fb sc fc
        vecs[0]  = '{1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{1, 3, 5, 1, 1, 4, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
        vecs[2]  = '{1, 3, 7, 1, 1, 6, 1, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0};
        vecs[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2, 0, 0, 0};
        vecs[4]  = '{1, 1, 0, 1, 0, 3, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
        vecs[5]  = '{1, 2, 3, 1, 1, 8, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
        vecs[6]  = '{1, 2, 3, 1, 1, 8, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0};
        vecs[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 2, 1, 0};
        vecs[8]  = '{1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0};
        vecs[9]  = '{1, 5, 5, 1, 1, 9, 1, 0, 1, 0, 1, 1, 1, 1, 0, 0, 1, 0};
        vecs[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1};
        vecs[11] = '{1, 1, 2, 1, 1, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1};
        vecs[12] = '{1, 0, 0, 1, 1, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1};
        vecs[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1};
        vecs[14] = '{1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1};
        vecs[15] = '{1, 0, 1, 1, 1, 2, 1, 0, 0, 0, 1, 1, 0, 0, 2, 0, 1, 1};
        vecs[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1};

        // Reset values, held in reset and just after release before any edge.
        #3;
        check("reset outs", outs, 8'b0001_0000);
        check("reset cnts", {stall_cnt, flush_cnt}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("release outs", outs, 8'b0001_0000);
        @(posedge clk);

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive_id(vecs[i].v, vecs[i].rs, vecs[i].rt, vecs[i].urs, vecs[i].urt,
                     vecs[i].dst, vecs[i].rw, vecs[i].mr);
            ex_redirect = vecs[i].redir;
            mem_busy = vecs[i].busy;
            #1;
            check($sformatf("vec%0d pc_en", i), pc_en, vecs[i].pc);
            check($sformatf("vec%0d ifid_en", i), ifid_en, vecs[i].ifid);
            check($sformatf("vec%0d ifid_flush", i), ifid_flush, vecs[i].fl);
            check($sformatf("vec%0d idex_bubble", i), idex_bubble, vecs[i].bub);
            check($sformatf("vec%0d fwd_a", i), fwd_a, vecs[i].fa);
            check($sformatf("vec%0d fwd_b", i), fwd_b, vecs[i].fb);
            check($sformatf("vec%0d stall_cnt", i), stall_cnt, vecs[i].sc);
            check($sformatf("vec%0d flush_cnt", i), flush_cnt, vecs[i].fc);
        end

        // Pending load-use frozen by mem_busy for 3 cycles, then resolved in 1.
        @(negedge clk);
        drive_id(1, 1, 0, 1, 0, 3, 1, 1);
        ex_redirect = 1'b0;
        #1 check("busy pre load", outs, 8'b1100_0000);
        @(negedge clk);
        drive_id(1, 2, 3, 1, 1, 8, 1, 0);
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("busy%0d outs", i), outs, 8'b0000_0000);
            check($sformatf("busy%0d cnts", i), {stall_cnt, flush_cnt}, {16'd1, 16'd1});
            @(negedge clk);
        end
        mem_busy = 1'b0;
        #1 check("busy release stall", outs, 8'b0001_0000);
        @(negedge clk);
        #1 check("busy after stall", outs, 8'b1100_0000);
        check("busy stall_cnt", stall_cnt, 16'd2);
        @(negedge clk);
        drive_id(0, 0, 0, 0, 0, 0, 0, 0);
        #1 check("busy load fwd_b", outs, 8'b1100_0010);

        // Randomized traffic against the reference model.
        do_reset();
        m_nop = '{0, 0, 0, 0, 0, 0, 0, 0};
        m_ex = m_nop; m_mem = m_nop; m_wb = m_nop;
        m_sc = 0; m_fc = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            m_id.v   = ($urandom_range(0, 3) != 0);
            m_id.rs  = 4'($urandom_range(0, 3));
            m_id.rt  = 4'($urandom_range(0, 3));
            m_id.dst = 4'($urandom_range(0, 3));
            m_id.urs = 1'($urandom);
            m_id.urt = 1'($urandom);
            m_id.rw  = ($urandom_range(0, 3) != 0);
            m_id.mr  = ($urandom_range(0, 9) < 3);
            ex_redirect = ($urandom_range(0, 99) < 8);
            mem_busy    = ($urandom_range(0, 99) < 15);
            drive_id(m_id.v, m_id.rs, m_id.rt, m_id.urs, m_id.urt, m_id.dst, m_id.rw, m_id.mr);

            lu = m_id.v && m_ex.mr &&
                 ((m_id.urs && writes(m_ex, m_id.rs)) || (m_id.urt && writes(m_ex, m_id.rt)));
            if (mem_busy)         exp_o[7:4] = 4'b0000;
            else if (ex_redirect) exp_o[7:4] = 4'b1111;
            else if (lu)          exp_o[7:4] = 4'b0001;
            else                  exp_o[7:4] = 4'b1100;
            exp_o[3:2] = model_fwd(m_ex.urs, m_ex.rs);
            exp_o[1:0] = model_fwd(m_ex.urt, m_ex.rt);
            #1;
            check($sformatf("rnd%0d outs", c), outs, exp_o);
            check($sformatf("rnd%0d cnts", c), {stall_cnt, flush_cnt}, {16'(m_sc), 16'(m_fc)});

            if (!mem_busy) begin
                if (ex_redirect) m_fc = (m_fc < 65535) ? m_fc + 1 : m_fc;
                else if (lu)     m_sc = (m_sc < 65535) ? m_sc + 1 : m_sc;
                m_wb  = m_mem;
                m_mem = m_ex;
                m_ex  = (m_id.v && !exp_o[4]) ? m_id : m_nop;
            end
        end

        // Drive flush_cnt into saturation, then reset in the middle of a stall.
        do_reset();
        @(negedge clk);
        ex_redirect = 1'b1;
        repeat (65534) @(posedge clk);
        @(negedge clk);
        check("flush near sat", flush_cnt, 16'hFFFE);
        @(negedge clk);
        check("flush sat", flush_cnt, 16'hFFFF);
        @(negedge clk);
        check("flush sat hold", flush_cnt, 16'hFFFF);
        ex_redirect = 1'b0;
        drive_id(1, 1, 0, 1, 0, 3, 1, 1);
        @(negedge clk);
        drive_id(1, 2, 3, 1, 1, 8, 1, 0);
        #1 check("sat stall outs", outs, 8'b0001_0000);
        check("sat stall flush", flush_cnt, 16'hFFFF);
        #2 reset_n = 1'b0;
        #1 check("midstall reset outs", outs, 8'b0001_0000);
        check("midstall reset cnts", {stall_cnt, flush_cnt}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        #1 check("midstall release", outs, 8'b0001_0000);
        @(negedge clk);
        #1 check("no stall survives", outs, 8'b1100_0000);
        check("post reset cnts", {stall_cnt, flush_cnt}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
